// File: rtl/mult_share_pkg.sv
// Shared types and round-robin helper for the shared-multiplier arbiter.
// Pure declarations; no latency or backpressure of its own.
// rr_pick supports up to RR_MAX requesters.
package mult_share_pkg;

  localparam int RR_MAX = 64;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    RESP
  } state_t;

  // Returns the first set bit of valid[n-1:0] searching upward from last+1
  // with wrap-around, or -1 when nothing is valid.
  function automatic int rr_pick(input logic [RR_MAX-1:0] valid, input int n, input int last);
    int idx;
    rr_pick = -1;
    for (int k = 1; k <= RR_MAX; k++) begin
      if (k <= n) begin
        idx = last + k;
        if (idx >= n) idx = idx - n;
        if (rr_pick < 0 && valid[idx[5:0]]) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/multsigned.sv
// Exact signed multiplier: product width is the sum of the operand widths.
// Latency: purely combinational.
// Backpressure: none; the caller registers around it.
module multsigned #(
  parameter int IN_SIZE_0 = 4,
  parameter int IN_SIZE_1 = 8,
  localparam int OUT_SIZE = IN_SIZE_0 + IN_SIZE_1
) (
  input  logic signed [IN_SIZE_0-1:0] a,
  input  logic signed [IN_SIZE_1-1:0] b,
  output logic signed [OUT_SIZE-1:0]  p
);

  assign p = OUT_SIZE'(a) * OUT_SIZE'(b);

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one signed multiplier among NUM_REQ requesters.
// Latency: 2 cycles from request accept to rsp_valid_o; one result per 2 cycles peak.
// Backpressure: rsp_ready_i low holds the result and blocks all req_ready_o.
import mult_share_pkg::*;

module mult_share_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IN_SIZE_0 = 4,
  parameter int IN_SIZE_1 = 8,
  localparam int OUT_SIZE = IN_SIZE_0 + IN_SIZE_1,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*IN_SIZE_0-1:0]   req_a_i,
  input  logic [NUM_REQ*IN_SIZE_1-1:0]   req_b_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [ID_W-1:0]                rsp_id_o,
  output logic [OUT_SIZE-1:0]            rsp_data_o
);

  state_t                       state;
  logic [ID_W-1:0]              last_grant;
  logic [ID_W-1:0]              id_q;
  logic signed [IN_SIZE_0-1:0]  a_q;
  logic signed [IN_SIZE_1-1:0]  b_q;
  logic signed [IN_SIZE_0-1:0]  a_sel;
  logic signed [IN_SIZE_1-1:0]  b_sel;
  logic signed [OUT_SIZE-1:0]   prod;
  logic [OUT_SIZE-1:0]          rsp_data_q;
  logic [ID_W-1:0]              rsp_id_q;
  logic                         rsp_valid_q;
  logic [RR_MAX-1:0]            valid_ext;
  logic                         accept_en;
  logic                         hs;
  int                           pick;

  // A new request may only enter when the multiplier slot is free this cycle.
  always_comb begin
    valid_ext = '0;
    valid_ext[NUM_REQ-1:0] = req_valid_i;
    accept_en = !rst_i && (state == IDLE || (state == RESP && rsp_ready_i));
    pick = rr_pick(valid_ext, NUM_REQ, int'(last_grant));
    req_ready_o = '0;
    a_sel = '0;
    b_sel = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (pick == r) begin
        a_sel = req_a_i[r*IN_SIZE_0 +: IN_SIZE_0];
        b_sel = req_b_i[r*IN_SIZE_1 +: IN_SIZE_1];
        if (accept_en) req_ready_o[r] = 1'b1;
      end
    end
    hs = |req_ready_o;
  end

  multsigned #(
    .IN_SIZE_0(IN_SIZE_0),
    .IN_SIZE_1(IN_SIZE_1)
  ) u_mult (
    .a(a_q),
    .b(b_q),
    .p(prod)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      last_grant  <= ID_W'(NUM_REQ - 1);
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) state <= MUL;
        end
        MUL: begin
          rsp_data_q  <= prod;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state       <= hs ? MUL : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (hs) begin
        a_q        <= a_sel;
        b_q        <= b_sel;
        id_q       <= ID_W'(pick);
        last_grant <= ID_W'(pick);
      end
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: directed scenarios plus random traffic,
// all cycles checked against a transaction-level reference model.
module tb_mult_share_arbiter;

  localparam int N  = 4;
  localparam int WA = 4;
  localparam int WB = 8;
  localparam int WO = WA + WB;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*WA-1:0]   req_a;
  logic [N*WB-1:0]   req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [WO-1:0]     rsp_data;

  int                n_checks = 0;
  int                n_errors = 0;
  int                resp_cnt = 0;
  logic [N-1:0]      acc = '0;

  mult_share_arbiter #(.NUM_REQ(N), .IN_SIZE_0(WA), .IN_SIZE_1(WB)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_data_o(rsp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int rand_a();
    case ($urandom % 4)
      0: return -8;
      1: return 7;
      default: return int'($urandom_range(15, 0)) - 8;
    endcase
  endfunction

  function automatic int rand_b();
    case ($urandom % 4)
      0: return -128;
      1: return 127;
      default: return int'($urandom_range(255, 0)) - 128;
    endcase
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic set_op(input int r, input int a, input int b);
    req_a[r*WA +: WA] = WA'(a);
    req_b[r*WB +: WB] = WB'(b);
  endtask

  // Requesters accepted last edge that remain valid present fresh operands.
  task automatic refresh();
    for (int r = 0; r < N; r++)
      if (acc[r] && req_valid[r]) set_op(r, rand_a(), rand_b());
  endtask

  // Reference model: one job slot, result visible 2 cycles after accept.
  initial begin
    int m_last;
    bit m_busy;
    int m_cd, m_id, m_data, win, av, bv;
    bit exp_v;
    logic [N-1:0] exp_rdy;
    logic signed [WO-1:0] d;
    m_last = N - 1; m_busy = 0; m_cd = 0; m_id = 0; m_data = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_v = m_busy && (m_cd == 0);
      exp_rdy = '0;
      win = -1;
      if (!rst && (!m_busy || (exp_v && rsp_ready))) begin
        for (int k = 1; k <= N; k++)
          if (win < 0 && req_valid[(m_last + k) % N]) win = (m_last + k) % N;
        if (win >= 0) exp_rdy[win] = 1'b1;
      end
      chk("model_rsp_valid", rsp_valid, exp_v);
      chk("model_req_ready", req_ready, exp_rdy);
      if (exp_v) begin
        d = rsp_data;
        chk("model_rsp_id", rsp_id, m_id);
        chk("model_rsp_data", d, m_data);
      end
      acc = req_valid & req_ready;
      if (rst) begin
        m_busy = 0;
        m_last = N - 1;
      end else begin
        if (m_busy) begin
          if (m_cd > 0) m_cd--;
          else if (rsp_ready) begin
            m_busy = 0;
            resp_cnt++;
          end
        end
        if (win >= 0) begin
          av = $signed(req_a[win*WA +: WA]);
          bv = $signed(req_b[win*WB +: WB]);
          m_busy = 1; m_cd = 1; m_id = win; m_data = av * bv; m_last = win;
        end
      end
    end
  end

  task automatic single(input int r, input int a, input int b, input int exp_p);
    logic signed [WO-1:0] d;
    @(posedge clk); #1;
    req_valid = '0; req_valid[r] = 1'b1; rsp_ready = 1'b1;
    set_op(r, a, b);
    @(negedge clk);
    chk("single_ready", req_ready, 1 << r);
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    @(negedge clk);
    chk("single_mul_no_valid", rsp_valid, 0);
    @(negedge clk);
    d = rsp_data;
    chk("single_valid", rsp_valid, 1);
    chk("single_id", rsp_id, r);
    chk("single_data", d, exp_p);
  endtask

  initial begin
    int g[6];
    int c[6];
    int cnt, start;
    bit found;
    logic [WO-1:0] cap_d;
    logic [IW-1:0] cap_id;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    rst = 1'b1; req_valid = '1; rsp_ready = 1'b0;
    for (int r = 0; r < N; r++) set_op(r, rand_a(), rand_b());
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_req_ready", req_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;

    single(2, -3, 25, -75);
    single(0, -8, -128, 1024);
    single(1, -8, 127, -1016);
    single(3, 7, -128, -896);

    // Reset while the multiplier holds an accepted request.
    @(posedge clk); #1;
    req_valid = '0; req_valid[2] = 1'b1; set_op(2, 5, 5);
    @(negedge clk);
    chk("rst_pre_ready", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid = '0; rst = 1'b1;
    @(negedge clk);
    chk("rst_ready_zero", req_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_resp", rsp_valid, 0);
      @(posedge clk); #1;
    end
    req_valid = '1;
    for (int r = 0; r < N; r++) set_op(r, rand_a(), rand_b());
    @(negedge clk);
    chk("rst_next_grant", req_ready, 4'b0001);

    // All four continuously valid: grants rotate every 2 cycles.
    cnt = 0;
    for (int t = 0; t < 30 && cnt < 5; t++) begin
      if (t > 0) @(negedge clk);
      if (req_ready != '0) begin
        g[cnt] = onehot_idx(req_ready); c[cnt] = t; cnt++;
      end
      @(posedge clk); #1;
      refresh();
    end
    if (cnt < 5) chk("rr_timeout", cnt, 5);
    else begin
      for (int i = 0; i < 5; i++) chk("rr_order", g[i], exp_order[i]);
      for (int i = 1; i < 5; i++) chk("rr_gap", c[i] - c[i-1], 2);
    end

    // Backpressure for 5 cycles once a result appears.
    rsp_ready = 1'b0;
    found = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (rsp_valid) begin found = 1; break; end
      @(posedge clk); #1;
      refresh();
    end
    if (!found) chk("bp_timeout", 0, 1);
    cap_d = rsp_data; cap_id = rsp_id;
    for (int t = 0; t < 5; t++) begin
      if (t > 0) @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data_stable", rsp_data, cap_d);
      chk("bp_id_stable", rsp_id, cap_id);
      chk("bp_ready_zero", req_ready, 0);
      @(posedge clk); #1;
      refresh();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume", $countones(req_ready), 1);

    // Fairness between a persistent and a re-asserting requester.
    @(posedge clk); #1;
    refresh();
    req_valid = 4'b0011;
    cnt = 0;
    for (int t = 0; t < 40 && cnt < 6; t++) begin
      @(negedge clk);
      if (req_ready != '0) begin g[cnt] = onehot_idx(req_ready); cnt++; end
      @(posedge clk); #1;
      refresh();
    end
    if (cnt < 6) chk("fair_timeout", cnt, 6);
    else begin
      for (int i = 0; i < 6; i++) chk("fair_range", g[i] <= 1, 1);
      for (int i = 1; i < 6; i++) chk("fair_alternate", g[i], 1 - g[i-1]);
    end

    // Random traffic with hold-until-accepted requesters.
    start = resp_cnt;
    for (int t = 0; t < 8000 && (resp_cnt - start) < 1100; t++) begin
      @(posedge clk); #1;
      for (int r = 0; r < N; r++) begin
        if (!req_valid[r] || acc[r]) begin
          req_valid[r] = ($urandom % 3) != 0;
          set_op(r, rand_a(), rand_b());
        end
      end
      rsp_ready = ($urandom % 4) != 0;
    end
    chk("random_resp_count", (resp_cnt - start) >= 1000, 1);

    @(posedge clk); #1;
    req_valid = '0; rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
